// File: rtl/instr_exec_ctrl.sv
// Four-state (IDLE/READ/EXEC/WB) controller that executes one 8-bit
// instruction at a time against an external 4-entry register file.
module instr_exec_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       instr_valid,
  input  logic [7:0] instr,
  output logic       instr_ready,
  input  logic [7:0] rs1_data,
  input  logic [7:0] rs2_data,
  output logic       rf_we,
  output logic [1:0] rf_rd,
  output logic [1:0] rf_rs1,
  output logic [1:0] rf_rs2,
  output logic [7:0] rf_wd,
  output logic       retire,
  output logic       zero_flag,
  output logic       carry_flag,
  output logic       busy
);

  localparam int unsigned DW = 8;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_t;

  state_t        state;
  state_t        state_next;
  logic          accept;

  logic [DW-1:0] instr_q;
  logic [DW-1:0] op_a;
  logic [DW-1:0] op_b;
  logic [DW-1:0] result_q;
  logic          carry_q;
  logic          carry_wr_q;

  logic [DW:0]   sum;
  logic [DW-1:0] alu_res;
  logic          alu_carry;
  logic          alu_carry_wr;

  // Register indices always come from the latched instruction.
  assign rf_rd  = instr_q[5:4];
  assign rf_rs1 = instr_q[3:2];
  assign rf_rs2 = instr_q[1:0];

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state logic; accept marks the instruction handshake.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (instr_valid) begin
          state_next = READ;
          accept     = 1'b1;
        end
      end
      READ:    state_next = EXEC;
      EXEC:    state_next = WB;
      WB:      state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ALU over the captured operands; AND/LI do not touch carry.
  always_comb begin
    sum          = {1'b0, op_a} + {1'b0, op_b};
    alu_res      = '0;
    alu_carry    = 1'b0;
    alu_carry_wr = 1'b0;
    case (instr_q[7:6])
      OP_ADD: begin
        alu_res      = sum[DW-1:0];
        alu_carry    = sum[DW];
        alu_carry_wr = 1'b1;
      end
      OP_SUB: begin
        alu_res      = op_a - op_b;
        alu_carry    = (op_a < op_b);
        alu_carry_wr = 1'b1;
      end
      OP_AND:  alu_res = op_a & op_b;
      default: alu_res = {4'b0000, instr_q[3:0]};
    endcase
  end

  // Instruction latch, operand capture and result register.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q    <= '0;
      op_a       <= '0;
      op_b       <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      carry_wr_q <= 1'b0;
    end else begin
      if (accept) instr_q <= instr;
      if (state == READ) begin
        op_a <= rs1_data;
        op_b <= rs2_data;
      end
      if (state == EXEC) begin
        result_q   <= alu_res;
        carry_q    <= alu_carry;
        carry_wr_q <= alu_carry_wr;
      end
    end
  end

  // Registered outputs decoded from the upcoming state; flags commit on leaving WB.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_ready <= 1'b1;
      busy        <= 1'b0;
      rf_we       <= 1'b0;
      retire      <= 1'b0;
      rf_wd       <= '0;
      zero_flag   <= 1'b0;
      carry_flag  <= 1'b0;
    end else begin
      instr_ready <= (state_next == IDLE);
      busy        <= (state_next != IDLE);
      rf_we       <= (state_next == WB);
      retire      <= (state_next == WB);
      rf_wd       <= (state_next == WB) ? alu_res : DW'(0);
      if (state == WB) begin
        zero_flag <= (result_q == DW'(0));
        if (carry_wr_q) carry_flag <= carry_q;
      end
    end
  end

endmodule
